// File: rtl/vertex_pkg.sv
// rtl/vertex_pkg.sv - shared vertex/triangle types and sequencer state encoding
package vertex_pkg;

  localparam int DEF_VIDX_W  = 8;
  localparam int DEF_VTX_W   = 108;
  localparam int DEF_TRANS_W = 384;
  localparam int DEF_IID_W   = 8;

  // Triangle RAM word: three vertex indices, v0 in the low field
  typedef struct packed {
    logic [DEF_VIDX_W-1:0] v2;
    logic [DEF_VIDX_W-1:0] v1;
    logic [DEF_VIDX_W-1:0] v0;
  } tri_idx_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INST,
    S_DESC_WAIT,
    S_TRI_ADDR,
    S_TRI_CAP,
    S_VTX,
    S_EMIT,
    S_NEXT_INST,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [DEF_IID_W-1:0]   inst_id;
    logic [DEF_TRANS_W-1:0] transform;
    logic [DEF_VTX_W-1:0]   v2;
    logic [DEF_VTX_W-1:0]   v1;
    logic [DEF_VTX_W-1:0]   v0;
  } assembled_tri_t;

endpackage

// File: rtl/raster_tri_sequencer.sv
// rtl/raster_tri_sequencer.sv - per-frame scene walker feeding assembled triangles to setup
module raster_tri_sequencer
  import vertex_pkg::*;
#(
  parameter int MAX_VERT = 8192,
  parameter int MAX_TRI  = 8192,
  parameter int MAX_INST = 256,
  parameter int VIDX_W   = DEF_VIDX_W,
  parameter int TIDX_W   = 8,
  parameter int VTX_W    = DEF_VTX_W,
  parameter int TRANS_W  = DEF_TRANS_W,
  parameter int DESC_LAT = 3,
  parameter int VADDR_W  = $clog2(MAX_VERT),
  parameter int TADDR_W  = $clog2(MAX_TRI),
  parameter int IID_W    = $clog2(MAX_INST),
  parameter int TRI_W    = 3 * VIDX_W
) (
  input  logic               clk,
  input  logic               rst_raster,
  input  logic               frame_start,
  input  logic [IID_W:0]     inst_count,
  output logic [IID_W-1:0]   inst_id_rd,
  input  logic [VADDR_W-1:0] desc_vert_base,
  input  logic [VIDX_W-1:0]  desc_vert_count,
  input  logic [TADDR_W-1:0] desc_tri_base,
  input  logic [TIDX_W-1:0]  desc_tri_count,
  input  logic [TRANS_W-1:0] transform_in,
  output logic [TADDR_W-1:0] tri_addr_rd,
  input  logic [TRI_W-1:0]   idx_tri_in,
  output logic [VADDR_W-1:0] vert_addr_rd,
  input  logic [VTX_W-1:0]   vert_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VTX_W-1:0]   out_v0,
  output logic [VTX_W-1:0]   out_v1,
  output logic [VTX_W-1:0]   out_v2,
  output logic [TRANS_W-1:0] out_transform,
  output logic [IID_W-1:0]   out_inst_id,
  output logic               busy,
  output logic               frame_done,
  output logic               idx_err
);

  localparam int WAIT_W = (DESC_LAT > 1) ? $clog2(DESC_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DESC_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [TIDX_W:0]   TRI_ONE   = (TIDX_W+1)'(1);
  localparam logic [IID_W:0]    INST_ONE  = (IID_W+1)'(1);

  seq_state_e             state;
  logic [IID_W:0]         inst_total;
  logic [IID_W:0]         inst_ctr;
  logic [WAIT_W-1:0]      wait_ctr;
  logic [VADDR_W-1:0]     vert_base_r;
  logic [VIDX_W-1:0]      vert_count_r;
  logic [TADDR_W-1:0]     tri_base_r;
  logic [TIDX_W-1:0]      tri_count_r;
  logic [TRANS_W-1:0]     transform_r;
  logic [TIDX_W:0]        tri_ctr;
  logic [2*VIDX_W-1:0]    idx_hi_r;
  logic [1:0]             vsel;
  logic [VTX_W-1:0]       vtx0_r;
  logic [VTX_W-1:0]       vtx1_r;
  logic [TADDR_W-1:0]     taddr_q;
  logic [VADDR_W-1:0]     vaddr_q;

  logic [VIDX_W-1:0]      cap_v0, cap_v1, cap_v2;
  logic [VIDX_W-1:0]      vidx_sel;
  logic [TADDR_W-1:0]     tri_addr_next;
  logic [VADDR_W-1:0]     vaddr_next;
  logic                   drive_v;
  logic [TIDX_W:0]        tri_last;
  logic [IID_W:0]         inst_last;

  assign cap_v0 = idx_tri_in[VIDX_W-1:0];
  assign cap_v1 = idx_tri_in[2*VIDX_W-1:VIDX_W];
  assign cap_v2 = idx_tri_in[3*VIDX_W-1:2*VIDX_W];

  assign tri_last  = {1'b0, tri_count_r} - TRI_ONE;
  assign inst_last = inst_total - INST_ONE;

  // RAM addresses are presented in the cycle of the issuing state so the
  // registered read data lands in the following state; otherwise they hold
  always_comb begin
    vidx_sel = cap_v0;
    if (state == S_VTX) begin
      vidx_sel = (vsel == 2'd0) ? idx_hi_r[VIDX_W-1:0] : idx_hi_r[2*VIDX_W-1:VIDX_W];
    end
    tri_addr_next = tri_base_r + TADDR_W'(tri_ctr);
    vaddr_next    = vert_base_r + VADDR_W'(vidx_sel);
    drive_v       = (state == S_TRI_CAP) || ((state == S_VTX) && (vsel != 2'd2));
    tri_addr_rd   = (state == S_TRI_ADDR) ? tri_addr_next : taddr_q;
    vert_addr_rd  = drive_v ? vaddr_next : vaddr_q;
  end

  // Frame walk: instance -> descriptors -> triangles -> vertices -> emit
  always_ff @(posedge clk or posedge rst_raster) begin
    if (rst_raster) begin
      state         <= S_IDLE;
      inst_total    <= '0;
      inst_ctr      <= '0;
      wait_ctr      <= '0;
      vert_base_r   <= '0;
      vert_count_r  <= '0;
      tri_base_r    <= '0;
      tri_count_r   <= '0;
      transform_r   <= '0;
      tri_ctr       <= '0;
      idx_hi_r      <= '0;
      vsel          <= '0;
      vtx0_r        <= '0;
      vtx1_r        <= '0;
      taddr_q       <= '0;
      vaddr_q       <= '0;
      inst_id_rd    <= '0;
      out_valid     <= 1'b0;
      out_v0        <= '0;
      out_v1        <= '0;
      out_v2        <= '0;
      out_transform <= '0;
      out_inst_id   <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      idx_err       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            inst_total <= inst_count;
            inst_ctr   <= '0;
            busy       <= 1'b1;
            idx_err    <= 1'b0;
            state      <= (inst_count == '0) ? S_DONE : S_INST;
          end
        end
        S_INST: begin
          inst_id_rd <= inst_ctr[IID_W-1:0];
          wait_ctr   <= '0;
          state      <= S_DESC_WAIT;
        end
        S_DESC_WAIT: begin
          if (wait_ctr == WAIT_LAST) begin
            vert_base_r  <= desc_vert_base;
            vert_count_r <= desc_vert_count;
            tri_base_r   <= desc_tri_base;
            tri_count_r  <= desc_tri_count;
            transform_r  <= transform_in;
            tri_ctr      <= '0;
            state        <= (desc_tri_count == '0) ? S_NEXT_INST : S_TRI_ADDR;
          end else begin
            wait_ctr <= wait_ctr + WAIT_ONE;
          end
        end
        S_TRI_ADDR: begin
          taddr_q <= tri_addr_next;
          state   <= S_TRI_CAP;
        end
        S_TRI_CAP: begin
          idx_hi_r <= {cap_v2, cap_v1};
          if ((cap_v0 >= vert_count_r) || (cap_v1 >= vert_count_r) || (cap_v2 >= vert_count_r)) begin
            idx_err <= 1'b1;
          end
          vaddr_q <= vaddr_next;
          vsel    <= 2'd0;
          state   <= S_VTX;
        end
        S_VTX: begin
          if (vsel == 2'd0) vtx0_r <= vert_in;
          if (vsel == 2'd1) vtx1_r <= vert_in;
          if (vsel != 2'd2) begin
            vaddr_q <= vaddr_next;
            vsel    <= vsel + 2'd1;
          end else begin
            out_v0        <= vtx0_r;
            out_v1        <= vtx1_r;
            out_v2        <= vert_in;
            out_transform <= transform_r;
            out_inst_id   <= inst_ctr[IID_W-1:0];
            out_valid     <= 1'b1;
            state         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            tri_ctr   <= tri_ctr + TRI_ONE;
            state     <= (tri_ctr == tri_last) ? S_NEXT_INST : S_TRI_ADDR;
          end
        end
        S_NEXT_INST: begin
          inst_ctr <= inst_ctr + INST_ONE;
          state    <= (inst_ctr == inst_last) ? S_DONE : S_INST;
        end
        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_tri_sequencer.sv
// tb/tb_raster_tri_sequencer.sv - directed self-checking bench for raster_tri_sequencer
module tb_raster_tri_sequencer;
  import vertex_pkg::*;

  logic          clk = 1'b0;
  logic          rst_raster;
  logic          frame_start;
  logic [8:0]    inst_count;
  logic [7:0]    inst_id_rd;
  logic [12:0]   desc_vert_base;
  logic [7:0]    desc_vert_count;
  logic [12:0]   desc_tri_base;
  logic [7:0]    desc_tri_count;
  logic [383:0]  transform_in;
  logic [12:0]   tri_addr_rd;
  logic [23:0]   idx_tri_in;
  logic [12:0]   vert_addr_rd;
  logic [107:0]  vert_in;
  logic          out_valid;
  logic          out_ready;
  logic [107:0]  out_v0, out_v1, out_v2;
  logic [383:0]  out_transform;
  logic [7:0]    out_inst_id;
  logic          busy, frame_done, idx_err;

  int n_tests = 0;
  int n_fail  = 0;

  raster_tri_sequencer dut (
    .clk(clk), .rst_raster(rst_raster), .frame_start(frame_start), .inst_count(inst_count),
    .inst_id_rd(inst_id_rd), .desc_vert_base(desc_vert_base), .desc_vert_count(desc_vert_count),
    .desc_tri_base(desc_tri_base), .desc_tri_count(desc_tri_count), .transform_in(transform_in),
    .tri_addr_rd(tri_addr_rd), .idx_tri_in(idx_tri_in), .vert_addr_rd(vert_addr_rd),
    .vert_in(vert_in), .out_valid(out_valid), .out_ready(out_ready), .out_v0(out_v0),
    .out_v1(out_v1), .out_v2(out_v2), .out_transform(out_transform), .out_inst_id(out_inst_id),
    .busy(busy), .frame_done(frame_done), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  // Scene memories and descriptor table
  logic [23:0] tri_mem [0:8191];
  logic [12:0] d_vb [0:255];
  logic [7:0]  d_vc [0:255];
  logic [12:0] d_tb [0:255];
  logic [7:0]  d_tc [0:255];

  function automatic logic [107:0] vdat(input logic [12:0] a);
    return {a, 8'h5A, 74'd0, a};
  endfunction

  function automatic logic [383:0] tdat(input logic [7:0] id);
    return {id, 368'd0, 8'hC3};
  endfunction

  function automatic logic [23:0] mk_word(input logic [7:0] v2, input logic [7:0] v1, input logic [7:0] v0);
    tri_idx_t w;
    w.v2 = v2;
    w.v1 = v1;
    w.v0 = v0;
    return w;
  endfunction

  assign desc_vert_base  = d_vb[inst_id_rd];
  assign desc_vert_count = d_vc[inst_id_rd];
  assign desc_tri_base   = d_tb[inst_id_rd];
  assign desc_tri_count  = d_tc[inst_id_rd];
  assign transform_in    = tdat(inst_id_rd);

  always @(posedge clk) begin
    idx_tri_in <= tri_mem[tri_addr_rd];
    vert_in    <= vdat(vert_addr_rd);
  end

  // Monitor: address change logs, handshakes, pulses
  int cyc = 0, fd_cnt = 0, busy_cnt = 0, ov_cnt = 0, fs_cyc = 0, fd_cyc = 0;
  logic [12:0]  last_va = '0, last_ta = '0;
  logic [12:0]  va_log[$], ta_log[$];
  logic [107:0] hs_v0[$], hs_v1[$], hs_v2[$];
  logic [383:0] hs_tr[$];
  logic [7:0]   hs_id[$];
  int           hs_cyc[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (vert_addr_rd != last_va) begin va_log.push_back(vert_addr_rd); last_va = vert_addr_rd; end
    if (tri_addr_rd != last_ta) begin ta_log.push_back(tri_addr_rd); last_ta = tri_addr_rd; end
    if (out_valid && out_ready) begin
      hs_v0.push_back(out_v0); hs_v1.push_back(out_v1); hs_v2.push_back(out_v2);
      hs_tr.push_back(out_transform); hs_id.push_back(out_inst_id); hs_cyc.push_back(cyc);
    end
    if (frame_start) fs_cyc = cyc;
    if (frame_done) begin fd_cnt = fd_cnt + 1; fd_cyc = cyc; end
    if (busy) busy_cnt = busy_cnt + 1;
    if (out_valid) ov_cnt = ov_cnt + 1;
  end

  task automatic start_frame(input int cnt);
    @(posedge clk); #1;
    inst_count  = 9'(cnt);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int fd0, input string name);
    int ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (fd_cnt > fd0) begin ok = 1; break; end
    end
    n_tests++;
    if (ok != 1) begin n_fail++; $display("FAIL %s_timeout: frame_done got %0d required 1", name, ok); end
  endtask

  task automatic test_reset();
    rst_raster = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({inst_id_rd, tri_addr_rd, vert_addr_rd, out_valid, out_v0, out_v1, out_v2, out_transform,
         out_inst_id, busy, frame_done, idx_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero, busy=%0b out_valid=%0b", busy, out_valid);
    end
    @(posedge clk); #1;
    rst_raster = 1'b0;
  endtask

  task automatic test_single();
    int va0 = va_log.size(), ta0 = ta_log.size(), hs0 = hs_id.size(), fd0 = fd_cnt;
    logic [12:0] exp_va [6] = '{13'd40, 13'd41, 13'd42, 13'd40, 13'd42, 13'd43};
    d_vb[0] = 13'd40; d_vc[0] = 8'd10; d_tb[0] = 13'd100; d_tc[0] = 8'd2;
    tri_mem[100] = mk_word(8'd2, 8'd1, 8'd0);
    tri_mem[101] = mk_word(8'd3, 8'd2, 8'd0);
    start_frame(1);
    wait_done(fd0, "single");
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (va_log.size() <= va0 + i || va_log[va0 + i] !== exp_va[i]) begin
        n_fail++; $display("FAIL single_vaddr[%0d]: got %0d required %0d", i,
                           (va_log.size() > va0 + i) ? va_log[va0 + i] : 13'h1fff, exp_va[i]);
      end
    end
    n_tests++;
    if (ta_log.size() != ta0 + 2 || ta_log[ta0] !== 13'd100 || ta_log[ta0 + 1] !== 13'd101) begin
      n_fail++; $display("FAIL single_taddr: %0d changes required 2 (100,101)", ta_log.size() - ta0);
    end
    n_tests++;
    if (hs_id.size() != hs0 + 2) begin
      n_fail++; $display("FAIL single_count: got %0d triangles required 2", hs_id.size() - hs0);
    end else begin
      n_tests++;
      if (hs_cyc[hs0 + 1] - hs_cyc[hs0] != 6) begin
        n_fail++; $display("FAIL single_spacing: got %0d cycles required 6", hs_cyc[hs0 + 1] - hs_cyc[hs0]);
      end
      n_tests++;
      if (hs_v0[hs0] !== vdat(40) || hs_v1[hs0] !== vdat(41) || hs_v2[hs0] !== vdat(42)) begin
        n_fail++; $display("FAIL single_tri0: v0=%h required %h", hs_v0[hs0], vdat(40));
      end
      n_tests++;
      if (hs_v0[hs0 + 1] !== vdat(40) || hs_v1[hs0 + 1] !== vdat(42) || hs_v2[hs0 + 1] !== vdat(43)) begin
        n_fail++; $display("FAIL single_tri1: v1=%h required %h", hs_v1[hs0 + 1], vdat(42));
      end
      n_tests++;
      if (hs_tr[hs0] !== tdat(0) || hs_id[hs0] !== 8'd0) begin
        n_fail++; $display("FAIL single_xform: id=%0d required 0", hs_id[hs0]);
      end
    end
    n_tests++;
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL single_done: got %0d pulses required 1", fd_cnt - fd0); end
    n_tests++;
    if (idx_err !== 1'b0) begin n_fail++; $display("FAIL single_idx_err: got %0b required 0", idx_err); end
  endtask

  task automatic test_zero_inst();
    int fd0 = fd_cnt, b0 = busy_cnt, ov0 = ov_cnt;
    start_frame(0);
    wait_done(fd0, "zero");
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (fd_cyc - fs_cyc != 2) begin n_fail++; $display("FAIL zero_latency: got %0d required 2", fd_cyc - fs_cyc); end
    n_tests++;
    if (busy_cnt - b0 != 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles required 1", busy_cnt - b0); end
    n_tests++;
    if (ov_cnt != ov0) begin n_fail++; $display("FAIL zero_valid: got %0d valid cycles required 0", ov_cnt - ov0); end
  endtask

  task automatic test_skip_empty();
    int hs0 = hs_id.size(), fd0 = fd_cnt;
    d_vb[0] = 13'd0;   d_vc[0] = 8'd8; d_tb[0] = 13'd200; d_tc[0] = 8'd1;
    d_vb[1] = 13'd900; d_vc[1] = 8'd8; d_tb[1] = 13'd250; d_tc[1] = 8'd0;
    d_vb[2] = 13'd500; d_vc[2] = 8'd8; d_tb[2] = 13'd300; d_tc[2] = 8'd1;
    tri_mem[200] = mk_word(8'd2, 8'd1, 8'd0);
    tri_mem[300] = mk_word(8'd0, 8'd1, 8'd2);
    start_frame(3);
    wait_done(fd0, "skip");
    n_tests++;
    if (hs_id.size() != hs0 + 2) begin
      n_fail++; $display("FAIL skip_count: got %0d triangles required 2", hs_id.size() - hs0);
    end else begin
      n_tests++;
      if (hs_id[hs0] !== 8'd0 || hs_id[hs0 + 1] !== 8'd2) begin
        n_fail++; $display("FAIL skip_ids: got %0d,%0d required 0,2", hs_id[hs0], hs_id[hs0 + 1]);
      end
      n_tests++;
      if (hs_v0[hs0 + 1] !== vdat(502) || hs_v2[hs0 + 1] !== vdat(500) || hs_tr[hs0 + 1] !== tdat(2)) begin
        n_fail++; $display("FAIL skip_data: v0=%h required %h", hs_v0[hs0 + 1], vdat(502));
      end
    end
  endtask

  task automatic test_backpressure();
    int hs0 = hs_id.size(), fd0 = fd_cnt, va0, ta0, seen = 0, moved = 0;
    logic [107:0] s0, s1, s2;
    logic [383:0] st;
    logic [7:0]   si;
    d_vb[0] = 13'd80; d_vc[0] = 8'd8; d_tb[0] = 13'd400; d_tc[0] = 8'd2;
    tri_mem[400] = mk_word(8'd1, 8'd0, 8'd2);
    tri_mem[401] = mk_word(8'd5, 8'd4, 8'd3);
    out_ready = 1'b0;
    start_frame(1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (out_valid) begin seen = 1; break; end
    end
    n_tests++;
    if (seen != 1) begin n_fail++; $display("FAIL stall_valid_timeout: got %0d required 1", seen); end
    s0 = out_v0; s1 = out_v1; s2 = out_v2; st = out_transform; si = out_inst_id;
    va0 = va_log.size(); ta0 = ta_log.size();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (!out_valid || out_v0 !== s0 || out_v1 !== s1 || out_v2 !== s2 ||
          out_transform !== st || out_inst_id !== si) moved++;
    end
    n_tests++;
    if (moved != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles required 0", moved); end
    n_tests++;
    if (s0 !== vdat(82) || s1 !== vdat(80) || s2 !== vdat(81)) begin
      n_fail++; $display("FAIL stall_data: v0=%h required %h", s0, vdat(82));
    end
    n_tests++;
    if (va_log.size() != va0 || ta_log.size() != ta0) begin
      n_fail++; $display("FAIL stall_reads: got %0d new reads required 0", va_log.size() - va0 + ta_log.size() - ta0);
    end
    out_ready = 1'b1;
    wait_done(fd0, "stall");
    n_tests++;
    if (hs_id.size() != hs0 + 2 || hs_v0[hs_v0.size() - 1] !== vdat(83) || hs_v2[hs_v2.size() - 1] !== vdat(85)) begin
      n_fail++; $display("FAIL stall_resume: got %0d triangles required 2", hs_id.size() - hs0);
    end
  endtask

  task automatic test_idx_err();
    int hs0 = hs_id.size(), fd0 = fd_cnt;
    d_vb[0] = 13'd60; d_vc[0] = 8'd5; d_tb[0] = 13'd500; d_tc[0] = 8'd1;
    tri_mem[500] = mk_word(8'd7, 8'd1, 8'd0);
    start_frame(1);
    wait_done(fd0, "idx");
    repeat (5) @(posedge clk);
    #2;
    n_tests++;
    if (idx_err !== 1'b1) begin n_fail++; $display("FAIL idx_err_set: got %0b required 1", idx_err); end
    n_tests++;
    if (hs_id.size() != hs0 + 1 || hs_v2[hs_v2.size() - 1] !== vdat(67)) begin
      n_fail++; $display("FAIL idx_err_fetch: got %0d triangles required 1 with v2 from 67", hs_id.size() - hs0);
    end
    d_vc[0] = 8'd8;
    fd0 = fd_cnt;
    start_frame(1);
    n_tests++;
    if (idx_err !== 1'b0) begin n_fail++; $display("FAIL idx_err_clear: got %0b required 0", idx_err); end
    wait_done(fd0, "idx_clean");
  endtask

  task automatic test_reset_mid_frame();
    int fd0 = fd_cnt, seen = 0;
    d_vb[0] = 13'd700; d_vc[0] = 8'd8; d_tb[0] = 13'd600; d_tc[0] = 8'd3;
    tri_mem[600] = mk_word(8'd2, 8'd1, 8'd0);
    start_frame(1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (vert_addr_rd == 13'd700) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    rst_raster = 1'b1;
    #1;
    n_tests++;
    if (seen != 1 || {inst_id_rd, tri_addr_rd, vert_addr_rd, out_valid, out_v0, out_v1, out_v2,
         out_transform, out_inst_id, busy, frame_done, idx_err} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: reached_vtx=%0d busy=%0b required outputs 0", seen, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_raster = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    n_tests++;
    if (fd_cnt != fd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_done: got %0d pulses busy=%0b required 0", fd_cnt - fd0, busy);
    end
  endtask

  task automatic test_tri_wrap();
    int ta0 = ta_log.size(), fd0 = fd_cnt;
    logic [12:0] exp_ta [4] = '{13'd8190, 13'd8191, 13'd0, 13'd1};
    d_vb[0] = 13'd10; d_vc[0] = 8'd8; d_tb[0] = 13'd8190; d_tc[0] = 8'd4;
    tri_mem[8190] = mk_word(8'd2, 8'd1, 8'd0);
    tri_mem[8191] = mk_word(8'd2, 8'd1, 8'd0);
    tri_mem[0]    = mk_word(8'd2, 8'd1, 8'd0);
    tri_mem[1]    = mk_word(8'd2, 8'd1, 8'd0);
    start_frame(1);
    wait_done(fd0, "wrap");
    n_tests++;
    if (ta_log.size() != ta0 + 4) begin
      n_fail++; $display("FAIL wrap_count: got %0d addresses required 4", ta_log.size() - ta0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ta_log[ta0 + i] !== exp_ta[i]) begin
          n_fail++; $display("FAIL wrap_taddr[%0d]: got %0d required %0d", i, ta_log[ta0 + i], exp_ta[i]);
        end
      end
    end
  endtask

  initial begin
    rst_raster  = 1'b1;
    frame_start = 1'b0;
    inst_count  = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < 8192; i++) tri_mem[i] = '0;
    for (int i = 0; i < 256; i++) begin d_vb[i] = '0; d_vc[i] = '0; d_tb[i] = '0; d_tc[i] = '0; end
    test_reset();
    test_single();
    test_zero_inst();
    test_skip_empty();
    test_backpressure();
    test_idx_err();
    test_reset_mid_frame();
    test_tri_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_tri_sequencer.md
Name: raster_tri_sequencer

Overview:
- Raster-domain (clk) controller that walks the stored scene once per frame and sequences the read ports of the raster memory.
- For each instance in turn it:
  - reads the instance record and its vertex/triangle descriptors;
  - steps through that instance's triangle list;
  - fetches the three vertices of each triangle.
- Each assembled triangle, with its transform and instance id, goes out over a valid/ready stream to the setup/rasteriser stage.
- Sole owner of inst_id_rd, tri_addr_rd and vert_addr_rd during a frame.

Parameters:
- MAX_VERT, 8192, vertex RAM depth; VADDR_W = $clog2(MAX_VERT).
- MAX_TRI, 8192, triangle RAM depth; TADDR_W = $clog2(MAX_TRI).
- MAX_INST, 256, instance slots; IID_W = $clog2(MAX_INST).
- VIDX_W, 8, per-vertex index width inside a triangle word; TRI_W = 3*VIDX_W.
- TIDX_W, 8, triangle count width.
- VTX_W, 108, vertex word width.
- TRANS_W, 384, transform width.
- DESC_LAT, 3, cycles from inst_id_rd change to valid descriptor/transform inputs (min 1).

Ports:
- clk  in  1  raster clock
- rst_raster  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse; begin walk
- inst_count  in  IID_W+1  instances to walk (0..MAX_INST); sampled on accepted frame_start
- inst_id_rd  out  IID_W  instance read address
- desc_vert_base  in  VADDR_W  vertex base of current instance
- desc_vert_count  in  VIDX_W  vertex count of current instance
- desc_tri_base  in  TADDR_W  triangle base of current instance
- desc_tri_count  in  TIDX_W  triangle count of current instance
- transform_in  in  TRANS_W  transform of current instance
- tri_addr_rd  out  TADDR_W  triangle RAM address
- idx_tri_in  in  TRI_W  triangle word, registered, valid 1 cycle after address
- vert_addr_rd  out  VADDR_W  vertex RAM address
- vert_in  in  VTX_W  vertex word, registered, valid 1 cycle after address
- out_valid  out  1  triangle available
- out_ready  in  1  downstream accepts
- out_v0, out_v1, out_v2  out  VTX_W each  vertices
- out_transform  out  TRANS_W  instance transform
- out_inst_id  out  IID_W  source instance
- busy  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse at end of walk
- idx_err  out  1  sticky: a vertex index was >= desc_vert_count this frame

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-frame aborts the frame immediately; no frame_done is emitted.
- IDLE:
  - frame_start latches inst_count into inst_total, sets inst_ctr=0, sets busy=1, clears idx_err.
  - If inst_total=0, go to DONE; otherwise go to INST.
- frame_start while busy is ignored.
- INST: drive inst_id_rd=inst_ctr (held until the next INST); reset wait counter; go to DESC_WAIT.
- DESC_WAIT:
  - Count DESC_LAT cycles, then latch vert_base, vert_count, tri_base, tri_count and transform into local registers.
  - If tri_count=0, go to NEXT_INST; otherwise set tri_ctr=0 and go to TRI_ADDR.
- TRI_ADDR: tri_addr_rd = tri_base + tri_ctr, truncated to TADDR_W (wraps mod MAX_TRI).
- TRI_CAP:
  - Capture idx_tri_in: v0 = bits [VIDX_W-1:0], v1 = next field, v2 = top field.
  - Drive vert_addr_rd = vert_base + v0, truncated mod MAX_VERT; set vsel=0; go to VTX.
- VTX, one cycle per vertex:
  - Capture vert_in into slot vsel.
  - If vsel<2, drive the address of vertex vsel+1.
  - After vsel=2, go to EMIT.
- Index check: any index >= vert_count sets idx_err. The fetch still proceeds with the unclamped address.
- EMIT:
  - out_valid=1 with registered out_v0..2, out_transform, out_inst_id.
  - While out_valid && !out_ready, all out_* hold stable.
  - On handshake: tri_ctr++; if tri_ctr==tri_count-1, go to NEXT_INST; otherwise go to TRI_ADDR.
- NEXT_INST: inst_ctr++; if inst_ctr==inst_total-1, go to DONE; otherwise go to INST.
- DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
- Throughput with out_ready held high: 6 cycles per triangle (TRI_ADDR, TRI_CAP, 3×VTX, EMIT). Instance overhead: DESC_LAT+2 cycles.
- Counters are one bit wider than their counts, so a count of 255 (or inst_count 256) does not wrap early.

Decomposition:
- Extend vertex_pkg with:
  - tri_idx_t: packed struct {v2, v1, v0}, each VIDX_W wide;
  - seq_state_e: the state enum;
  - assembled_tri_t: {inst_id, transform, v2, v1, v0}.
- No sub-module. The address adders and the DESC_LAT wait counter are inline.

Test Plan:
- One instance, tri_base=100, tri_count=2, vert_base=40, words {2,1,0} and {3,2,0}, ready=1 -> vert_addr_rd sequence 40, 41, 42, 40, 42, 43; two out triangles 6 cycles apart; frame_done once; idx_err=0.
- inst_count=0 -> frame_done 2 cycles after frame_start; no out_valid; busy high exactly 1 cycle.
- Three instances, middle one tri_count=0 -> output only from ids 0 and 2; out_inst_id values 0, 2.
- out_ready low 10 cycles during EMIT -> out_* bit-identical throughout; no extra reads issued; handshake resumes the sequence.
- Word with index 7, vert_count=5 -> idx_err=1 until next frame_start; triangle still emitted from address vert_base+7.
- rst_raster asserted during VTX, and tri_base=8190 with 4 triangles -> reset gives all outputs 0 and no frame_done; the wrap case gives tri_addr_rd sequence 8190, 8191, 0, 1.
